// File: rtl/banco_pkg.sv
// Shared constants for the register file, the N-bit ALU and the control unit.
//   REG_ZERO    : architectural index of the hardwired-zero register (x0)
//   N_DEFAULT   : default datapath width
//   AW_DEFAULT  : default register address width (2**AW registers)
package banco_pkg;
    localparam int REG_ZERO   = 0;
    localparam int N_DEFAULT  = 4;
    localparam int AW_DEFAULT = 3;
endpackage : banco_pkg

// File: rtl/reg_nbits.sv
// N-bit D register with load enable and asynchronous active-high clear.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high clear (dominates en)
//   en  : load enable
//   d   : data in
//   q   : registered data out
module reg_nbits #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : reg_nbits

// File: rtl/banco_registros_nbits.sv
// Register file feeding the N-bit ALU: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, optional write-through bypass.
// Ports:
//   clk_i, rst_i : clock (rising edge) and asynchronous active-high reset
//   rs1_i, rs2_i : read addresses (port 1 -> ALU a_i, port 2 -> ALU b_i)
//   rd_i, wd_i   : write address / write data
//   we_i         : write enable
//   rd1_o, rd2_o : read data
//   zero1_o      : rd1_o == 0
//   eq_o         : rd1_o == rd2_o
// Handshake: none; reads are purely combinational, a write with we_i=1 and
// rd_i!=0 lands on the next rising edge while rst_i is low.
module banco_registros_nbits
    import banco_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int AW     = AW_DEFAULT,
    parameter int BYPASS = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    input  logic [AW-1:0] rd_i,
    input  logic [N-1:0]  wd_i,
    input  logic          we_i,
    output logic [N-1:0]  rd1_o,
    output logic [N-1:0]  rd2_o,
    output logic          zero1_o,
    output logic          eq_o
);

    localparam int NREGS = 1 << AW;

    logic [NREGS-1:0][N-1:0] regs;
    logic                    wr_active;

    // x0 is a constant: there is no storage behind it, so writes to it vanish.
    assign regs[REG_ZERO] = '0;

    generate
        for (genvar i = 1; i < NREGS; i++) begin : g_reg
            reg_nbits #(.N(N)) u_reg (
                .clk (clk_i),
                .rst (rst_i),
                .en  (we_i && (rd_i == AW'(i))),
                .d   (wd_i),
                .q   (regs[i])
            );
        end
    endgenerate

    // A write counts for bypass only when it would actually commit; during
    // reset the array is being cleared, so forwarding wd_i would leak data.
    assign wr_active = we_i && !rst_i && (rd_i != AW'(REG_ZERO));

    always_comb begin
        rd1_o = regs[rs1_i];
        rd2_o = regs[rs2_i];
        if (BYPASS != 0) begin
            if (wr_active && (rs1_i == rd_i)) rd1_o = wd_i;
            if (wr_active && (rs2_i == rd_i)) rd2_o = wd_i;
        end
    end

    // Flags are taken after the bypass so branch pre-decode sees forwarded data.
    assign zero1_o = (rd1_o == '0);
    assign eq_o    = (rd1_o == rd2_o);

endmodule : banco_registros_nbits

// File: tb/tb_banco_registros_nbits.sv
module tb_banco_registros_nbits;

    localparam int N  = 4;
    localparam int AW = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] rs1, rs2, rd;
    logic [N-1:0]  wd;
    logic          we;

    logic [N-1:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic         zero1_0, eq_0, zero1_1, eq_1;

    banco_registros_nbits #(.N(N), .AW(AW), .BYPASS(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .wd_i(wd), .we_i(we), .rd1_o(rd1_0), .rd2_o(rd2_0),
        .zero1_o(zero1_0), .eq_o(eq_0)
    );

    banco_registros_nbits #(.N(N), .AW(AW), .BYPASS(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .wd_i(wd), .we_i(we), .rd1_o(rd1_1), .rd2_o(rd2_1),
        .zero1_o(zero1_1), .eq_o(eq_1)
    );

    // scoreboard: {rd1 no-bypass, rd2 no-bypass, rd1 bypass, rd2 bypass}
    logic [4*N-1:0] exp_q[$];
    string          name_q[$];
    event           sample_ev;
    int             checks = 0;
    int             errors = 0;

    task automatic cmp(input string nm, input string fld, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // monitor
    initial begin
        logic [4*N-1:0] v;
        string          nm;
        logic [N-1:0]   e10, e20, e11, e21;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                v  = exp_q.pop_front();
                nm = name_q.pop_front();
                {e10, e20, e11, e21} = v;
                cmp(nm, "rd1_nobyp", rd1_0, e10);
                cmp(nm, "rd2_nobyp", rd2_0, e20);
                cmp(nm, "zero1_nobyp", N'(zero1_0), N'(e10 == '0));
                cmp(nm, "eq_nobyp", N'(eq_0), N'(e10 == e20));
                cmp(nm, "rd1_byp", rd1_1, e11);
                cmp(nm, "rd2_byp", rd2_1, e21);
                cmp(nm, "zero1_byp", N'(zero1_1), N'(e11 == '0));
                cmp(nm, "eq_byp", N'(eq_1), N'(e11 == e21));
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string nm, input logic [N-1:0] a0, input logic [N-1:0] b0,
                         input logic [N-1:0] a1, input logic [N-1:0] b1);
        #1;
        exp_q.push_back({a0, b0, a1, b1});
        name_q.push_back(nm);
        -> sample_ev;
        #1;
    endtask

    function automatic logic [N-1:0] fill_val(input int r);
        return N'(2 * r + 1);
    endfunction

    // watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; we = 1'b0; rd = '0; wd = '0; rs1 = '0; rs2 = '0;
        #1;
        // reset held with an attempted write of F to reg3
        rst = 1'b1; we = 1'b1; rd = 3'd3; wd = 4'hF; rs1 = 3'd3; rs2 = 3'd3;
        step();
        check("rst_hold", 0, 0, 0, 0);
        for (int r = 0; r < 8; r++) begin
            rs1 = AW'(r); rs2 = AW'(7 - r);
            check("rst_scan", 0, 0, 0, 0);
        end
        step();
        rs1 = 3'd3; rs2 = 3'd3;
        check("rst_hold2", 0, 0, 0, 0);
        rst = 1'b0; we = 1'b0;
        step();

        // write / readback
        we = 1'b1; rd = 3'd3; wd = 4'hA;
        step();
        rd = 3'd5; wd = 4'h5;
        step();
        we = 1'b0; rs1 = 3'd3; rs2 = 3'd5;
        check("wr_rb", 4'hA, 4'h5, 4'hA, 4'h5);

        // x0 protection
        we = 1'b1; rd = 3'd0; wd = 4'h7; rs1 = 3'd0; rs2 = 3'd0;
        check("x0_pre", 0, 0, 0, 0);
        step();
        check("x0_post", 0, 0, 0, 0);
        we = 1'b0;

        // read during write on reg2: old 1, new 9
        we = 1'b1; rd = 3'd2; wd = 4'h1;
        step();
        wd = 4'h9; rs1 = 3'd2; rs2 = 3'd2;
        check("rdw_pre", 4'h1, 4'h1, 4'h9, 4'h9);
        rs2 = 3'd3;
        check("rdw_pre_port2", 4'h1, 4'hA, 4'h9, 4'hA);
        step();
        we = 1'b0; rs2 = 3'd2;
        check("rdw_post", 4'h9, 4'h9, 4'h9, 4'h9);

        // fill reg1..7 then read back
        for (int r = 1; r < 8; r++) begin
            we = 1'b1; rd = AW'(r); wd = fill_val(r);
            step();
        end
        we = 1'b0;
        for (int r = 1; r < 8; r++) begin
            rs1 = AW'(r); rs2 = AW'(8 - r);
            check("fill_rb", fill_val(r), fill_val(8 - r), fill_val(r), fill_val(8 - r));
        end

        // asynchronous reset pulse between edges
        step();
        rst = 1'b1; rs1 = 3'd1; rs2 = 3'd7;
        check("arst_on", 0, 0, 0, 0);
        rst = 1'b0; we = 1'b1; rd = 3'd6; wd = 4'hC; rs1 = 3'd6; rs2 = 3'd1;
        check("arst_off", 0, 0, 4'hC, 0);
        step();
        we = 1'b0;
        check("arst_first_wr", 4'hC, 0, 4'hC, 0);

        // ALU loop: reg4 <= reg1 + reg2
        we = 1'b1; rd = 3'd1; wd = 4'h3;
        step();
        rd = 3'd2; wd = 4'h4;
        step();
        we = 1'b0; rs1 = 3'd1; rs2 = 3'd2;
        check("alu_ops", 4'h3, 4'h4, 4'h3, 4'h4);
        wd = rd1_0 + rd2_0; rd = 3'd4; we = 1'b1;
        step();
        we = 1'b0; rs1 = 3'd4; rs2 = 3'd4;
        check("alu_wb", 4'h7, 4'h7, 4'h7, 4'h7);

        // drain scoreboard with a bound
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_banco_registros_nbits
